// File: rtl/inst_mem_responder.sv
// inst_mem_responder
//   Responder end of the instruction-fetch ROM interface. A read request
//   (en, addr) is accepted in IDLE. After WAIT_STATES wait cycles, a single
//   done strobe returns one instruction word. A misaligned or out-of-range
//   address gets done together with err one cycle after the request is
//   accepted. The word array is not reset, and a write port is provided to
//   preload the program image.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high
//   en       in   read request, held high until done is seen
//   addr     in   byte address of the requested word
//   data     out  returned instruction word (registered, holds until next load)
//   done     out  one-cycle completion strobe (also on error)
//   err      out  one-cycle error strobe, coincident with done
//   busy     out  high while waiting out the wait states
//   wr_en    in   preload write enable
//   wr_addr  in   preload byte address
//   wr_data  in   preload data
module inst_mem_responder #(
  parameter int unsigned     WORD        = 16,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter int unsigned     WAIT_STATES = 2,
  parameter logic [WORD-1:0] BASE_ADDR   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [WORD-1:0] addr,
  output logic [WORD-1:0] data,
  output logic            done,
  output logic            err,
  output logic            busy,
  input  logic            wr_en,
  input  logic [WORD-1:0] wr_addr,
  input  logic [WORD-1:0] wr_data
);

  localparam int unsigned     OFS        = $clog2(WORD / 8);
  localparam int unsigned     IW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WORD-1:0] ALIGN_MASK = WORD'((1 << OFS) - 1);
  localparam logic [WORD:0]   DEPTH_LIM  = (WORD + 1)'(DEPTH_WORDS);
  localparam int unsigned     CW         = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0]   CNT_INIT   = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // When OFS is 0 the alignment mask is all zeros, so every byte address
  // counts as aligned. This avoids a zero-width slice.
  function automatic logic f_valid(input logic [WORD-1:0] a);
    logic [WORD-1:0] rel;
    rel = a - BASE_ADDR;
    return ((a & ALIGN_MASK) == '0) && (a >= BASE_ADDR) &&
           ({1'b0, rel >> OFS} < DEPTH_LIM);
  endfunction

  function automatic logic [IW-1:0] f_index(input logic [WORD-1:0] a);
    return IW'((a - BASE_ADDR) >> OFS);
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [WORD-1:0] r_req_addr;
  logic [WORD-1:0] r_data;
  logic            r_err_pend;
  logic            w_accept;
  logic            w_load;
  logic            w_req_ok;
  logic [WORD-1:0] w_rd_addr;

  logic [WORD-1:0] r_mem [DEPTH_WORDS];

  assign w_req_ok = f_valid(addr);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. w_load marks the edge that enters RESP on a valid
  // request. With zero wait states that edge is also the accept edge, so
  // the read address comes straight from the live addr input and not from
  // the latched copy.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_rd_addr   = r_req_addr;
    unique case (r_state)
      S_IDLE: begin
        if (en) begin
          w_accept  = 1'b1;
          w_rd_addr = addr;
          if (!w_req_ok) begin
            w_state_nxt = S_RESP;
          end else if (WAIT_STATES == 0) begin
            w_state_nxt = S_RESP;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          w_load      = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request tracking, wait counter and returned data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_req_addr <= '0;
      r_err_pend <= 1'b0;
      r_data     <= '0;
    end else begin
      if (w_accept) begin
        r_req_addr <= addr;
        r_err_pend <= !w_req_ok;
        r_cnt      <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_load) begin
        r_data <= r_mem[f_index(w_rd_addr)];
      end
    end
  end

  // Preload port. It is independent of the FSM. A write and a read of the
  // same word on the same edge return the old contents.
  always_ff @(posedge clk) begin
    if (wr_en && f_valid(wr_addr)) begin
      r_mem[f_index(wr_addr)] <= wr_data;
    end
  end

  // Outputs
  always_comb begin
    done = (r_state == S_RESP);
    err  = (r_state == S_RESP) && r_err_pend;
    busy = (r_state == S_WAIT);
  end

  assign data = r_data;

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder
//   Two responders share one stimulus stream. One has two wait states and
//   the other has none. A request-level reference model predicts done, err,
//   busy and data for each responder after every clock edge.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        reset, en, wr_en;
  logic [15:0] addr, wr_addr, wr_data;
  logic [15:0] data_a, data_z;
  logic        done_a, err_a, busy_a, done_z, err_z, busy_z;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  inst_mem_responder #(
    .WORD(16), .DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(16'h0000)
  ) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .addr(addr),
    .data(data_a), .done(done_a), .err(err_a), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  inst_mem_responder #(
    .WORD(16), .DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(16'h0000)
  ) u_dut_z (
    .clk(clk), .reset(reset), .en(en), .addr(addr),
    .data(data_z), .done(done_z), .err(err_z), .busy(busy_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Reference model: the program image, plus the outstanding request of
  // each responder, described as "wait cycles left" and "responding now".
  logic [15:0] mm [1024];
  int          m_busy [2];
  bit          m_resp [2];
  bit          m_rerr [2];
  logic [15:0] m_req  [2];
  logic [15:0] m_data [2];
  int          m_ws   [2] = '{2, 0};

  function automatic bit good(input logic [15:0] a);
    return (a[0] == 1'b0) && (a < 16'h0800);
  endfunction

  function automatic logic [9:0] widx(input logic [15:0] a);
    return a[10:1];
  endfunction

  function automatic logic [15:0] rand_addr();
    int unsigned r;
    logic [15:0] v;
    r = $urandom_range(0, 9);
    v = 16'($urandom);
    if (r < 6)       return {5'b00000, v[9:0], 1'b0};
    else if (r < 8)  return {5'b00000, v[9:0], 1'b1};
    else if (r == 8) return {5'b00001, v[10:0]};
    else             return v;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 0;
        m_resp[k] = 1'b0;
        m_rerr[k] = 1'b0;
        m_data[k] = 16'h0000;
      end else if (m_resp[k]) begin
        m_resp[k] = 1'b0;
      end else if (m_busy[k] > 0) begin
        if (!en) begin
          m_busy[k] = 0;
        end else begin
          m_busy[k]--;
          if (m_busy[k] == 0) begin
            m_resp[k] = 1'b1;
            m_rerr[k] = 1'b0;
            m_data[k] = mm[widx(m_req[k])];
          end
        end
      end else if (en) begin
        m_req[k] = addr;
        if (!good(addr)) begin
          m_resp[k] = 1'b1;
          m_rerr[k] = 1'b1;
        end else if (m_ws[k] == 0) begin
          m_resp[k] = 1'b1;
          m_rerr[k] = 1'b0;
          m_data[k] = mm[widx(addr)];
        end else begin
          m_busy[k] = m_ws[k];
        end
      end
    end
    // Reads above see the contents from before this edge's write
    if (wr_en && good(wr_addr)) mm[widx(wr_addr)] = wr_data;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("A.done", {15'd0, done_a}, {15'd0, m_resp[0]});
    chk("A.err",  {15'd0, err_a},  {15'd0, m_resp[0] && m_rerr[0]});
    chk("A.busy", {15'd0, busy_a}, {15'd0, m_busy[0] > 0});
    chk("A.data", data_a, m_data[0]);
    chk("Z.done", {15'd0, done_z}, {15'd0, m_resp[1]});
    chk("Z.err",  {15'd0, err_z},  {15'd0, m_resp[1] && m_rerr[1]});
    chk("Z.busy", {15'd0, busy_z}, {15'd0, m_busy[1] > 0});
    chk("Z.data", data_z, m_data[1]);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    step();
    chk("rst.data", data_a, 16'h0000);
    chk("rst.done", {15'd0, done_a}, 16'd0);
    reset = 1'b0;

    // Preload the entire image, then place a known word at 0x0004
    for (int i = 0; i < 1024; i++) begin
      wr_en = 1'b1; wr_addr = 16'(2 * i); wr_data = 16'($urandom);
      step();
    end
    wr_addr = 16'h0004; wr_data = 16'h1234;
    step();
    wr_en = 1'b0;

    // Valid read with two wait states
    en = 1'b1; addr = 16'h0004;
    step(); chk("t1.busy1", {15'd0, busy_a}, 16'd1); chk("t1.nodone1", {15'd0, done_a}, 16'd0);
    step(); chk("t1.busy2", {15'd0, busy_a}, 16'd1);
    step(); chk("t1.done", {15'd0, done_a}, 16'd1); chk("t1.data", data_a, 16'h1234);
            chk("t1.err", {15'd0, err_a}, 16'd0);
    en = 1'b0;
    step(); chk("t1.idle", {15'd0, done_a | busy_a}, 16'd0);

    // Misaligned address
    en = 1'b1; addr = 16'h0005;
    step(); chk("t2.done", {15'd0, done_a}, 16'd1); chk("t2.err", {15'd0, err_a}, 16'd1);
            chk("t2.data", data_a, 16'h1234); chk("t2.busy", {15'd0, busy_a}, 16'd0);
    en = 1'b0;
    step();

    // Out-of-range address
    en = 1'b1; addr = 16'h0800;
    step(); chk("t3.done", {15'd0, done_a}, 16'd1); chk("t3.err", {15'd0, err_a}, 16'd1);
    en = 1'b0;
    step();

    // Abort in the first wait cycle, then a clean retry
    en = 1'b1; addr = 16'h0002;
    step();
    en = 1'b0;
    step(); chk("t4.abort", {15'd0, done_a | busy_a}, 16'd0);
    step(); chk("t4.nodone", {15'd0, done_a}, 16'd0);
    en = 1'b1;
    step(); step();
    step(); chk("t4.done", {15'd0, done_a}, 16'd1); chk("t4.data", data_a, mm[1]);
    en = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Zero wait states: back-to-back requests with en held high
    en = 1'b1; addr = 16'h0000;
    step(); chk("t5.done1", {15'd0, done_z}, 16'd1); chk("t5.data1", data_z, mm[0]);
    addr = 16'h0002;
    step(); chk("t5.idle", {15'd0, done_z}, 16'd0);
    step(); chk("t5.done2", {15'd0, done_z}, 16'd1); chk("t5.data2", data_z, mm[1]);
    en = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Reset in the middle of a wait
    en = 1'b1; addr = 16'h0004;
    step(); chk("t6.busy", {15'd0, busy_a}, 16'd1);
    reset = 1'b1;
    step(); chk("t6.quiet", {15'd0, done_a | err_a | busy_a}, 16'd0);
            chk("t6.data0", data_a, 16'h0000);
    reset = 1'b0; en = 1'b0;
    step();
    en = 1'b1;
    step(); step();
    step(); chk("t6.done", {15'd0, done_a}, 16'd1); chk("t6.data", data_a, 16'h1234);
    en = 1'b0;
    step();

    // Random traffic with occasional preload writes and resets
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      en      = ($urandom_range(0, 3) != 0);
      addr    = rand_addr();
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_addr = rand_addr();
      wr_data = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Responder end of the instruction-fetch ROM interface: accepts a read request (en, addr) from the fetch unit and returns one instruction word with a done strobe after a programmable number of wait states.
- Flags misaligned and out-of-range addresses with err.
- Holds the word-organised instruction array and provides a write port for program preload by the testbench or loader.
- Sits between the fetch unit's ROM_* outputs and the program image.

Parameters:
- WORD, 16, data and address width in bits; must be a multiple of 8.
- DEPTH_WORDS, 1024, number of WORD-wide entries in the array.
- WAIT_STATES, 2, extra cycles between request accept and done; 0 is legal.
- BASE_ADDR, 16'h0000, byte address of array entry 0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  read request; held high by the requester until done is seen.
- addr  in  WORD  byte address of the requested word.
- data  out  WORD  returned instruction word; registered.
- done  out  1  one-cycle completion strobe, also asserted on error.
- err  out  1  one-cycle error strobe, coincident with done.
- busy  out  1  high while a request is in progress (WAIT state).
- wr_en  in  1  preload write enable.
- wr_addr  in  WORD  preload byte address.
- wr_data  in  WORD  preload data.

Behaviour:
- Constants:
  - OFS = $clog2(WORD/8).
  - Index = (addr - BASE_ADDR) >> OFS.
  - misaligned = |addr[OFS-1:0].
  - out_of_range = (addr < BASE_ADDR) or (index >= DEPTH_WORDS).
- Reset:
  - Forces state IDLE, wait counter 0, data 0, done 0, err 0, busy 0.
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with en=1, the request is accepted: addr is latched into req_addr and validity is evaluated on the latched value.
  - Invalid request: go to RESP with err_pending=1.
  - Valid request with WAIT_STATES=0: go directly to RESP.
  - Valid request otherwise: go to WAIT with counter = WAIT_STATES-1.
- WAIT:
  - busy=1.
  - Counter decrements each cycle; at 0 the next state is RESP.
  - en=0 in WAIT aborts: return to IDLE, no done, data unchanged.
- RESP (one cycle):
  - done=1.
  - Valid request: data loads array[index of req_addr] on the edge entering RESP, so data is valid while done=1. err=0.
  - Invalid request: err=1 and data is held at its previous value.
  - Next state is always IDLE, regardless of en.
  - A new request is accepted no earlier than the first IDLE cycle, even if en is still high.
- Latency:
  - Valid request: done is asserted WAIT_STATES+1 cycles after the accept edge.
  - Invalid request: done is asserted 1 cycle after the accept edge.
- data holds its value after done until the next successful RESP.
- Preload writes:
  - wr_en writes array[wr index] on the clock edge, in any state.
  - Misaligned or out-of-range writes are silently dropped.
  - A write in the same cycle as the RESP data load to the same index: data gets the old contents (read-before-write).
- done and err are never asserted outside RESP. err is never high without done.
- Reset asserted mid-request overrides everything in the same cycle: no done pulse is produced for the aborted request.

Test Plan:
- Preload 16'h1234 at byte addr 0x0004; en=1 with addr=0x0004 held, WAIT_STATES=2 -> busy high 2 cycles, done=1 and data=16'h1234 exactly 3 cycles after accept, err=0; next cycle back in IDLE.
- addr=0x0005 -> done=1 and err=1 one cycle after accept; data unchanged from the prior value; busy never asserts.
- addr=0x0800 with DEPTH_WORDS=1024, BASE_ADDR=0 -> err=1 and done=1 after one cycle.
- Request to 0x0002, then deassert en in the first WAIT cycle -> no done, state returns to IDLE; a subsequent request to 0x0002 completes normally.
- WAIT_STATES=0; back-to-back requests to 0x0000 then 0x0002 with en held high -> done on cycle 1, IDLE on cycle 2, second accept, done on cycle 3 with the second word.
- Assert reset during WAIT -> done, err, and busy are 0, data=0 on the next cycle; preloaded contents still readable afterwards.
